// File: rtl/reduce9_pkg.sv
// reduce9_pkg: shared types and constants for the nine-byte reduction controller.
//   op_e    : reduction select carried on the op port (MAX, MIN, SUM, XOR)
//   state_e : controller FSM states
//   NUM_BYTES, W : default word geometry (bytes per word, bits per byte)
package reduce9_pkg;

    localparam int NUM_BYTES = 9;
    localparam int W         = 8;

    typedef enum logic [1:0] {
        OP_MAX = 2'd0,
        OP_MIN = 2'd1,
        OP_SUM = 2'd2,
        OP_XOR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/reduce9_ctrl_byte_alu.sv
// byte_alu: combinational byte reduction step shared by every fold.
//   op    in  2 : reduction select (op_e)
//   a     in  W : running accumulator
//   b     in  W : next byte
//   y     out W : reduced value
//   carry out 1 : carry out of the SUM adder, 0 for the other ops
module byte_alu
    import reduce9_pkg::*;
#(
    parameter int W = reduce9_pkg::W
) (
    input  op_e          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         carry
);

    logic [W:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_MAX: y = (a >= b) ? a : b;
            OP_MIN: y = (a <= b) ? a : b;
            OP_SUM: begin
                y     = sum[W-1:0];
                carry = sum[W];
            end
            OP_XOR: y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/reduce9_ctrl.sv
// reduce9_ctrl: folds a word of NUM_BYTES packed bytes one byte per clock
// through a single byte_alu (max / min / modular sum / xor).
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : producer handshake, in_data = packed bytes (byte 0 at LSB)
//   op                   : reduction select, captured on the accepting edge
//   out_valid/out_ready  : consumer handshake
//   out_data, out_ovf    : result and SUM carry-out flag, valid only in DONE
//   busy                 : high whenever not IDLE
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// RUN   | folding bytes 1..NUM_BYTES-1 into acc, one per clock
// DONE  | result presented, held until the consumer takes it
module reduce9_ctrl #(
    parameter int NUM_BYTES = reduce9_pkg::NUM_BYTES,
    parameter int W         = reduce9_pkg::W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_BYTES*W-1:0] in_data,
    input  logic [1:0]             op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic                   out_ovf,
    output logic                   busy
);

    import reduce9_pkg::*;

    localparam logic [3:0] LAST_CNT = 4'(NUM_BYTES - 1);

    state_e                 state, state_nxt;
    op_e                    op_r;
    logic [NUM_BYTES*W-1:0] sh;
    logic [W-1:0]           acc;
    logic [3:0]             cnt;
    logic                   ovf;
    logic [W-1:0]           alu_y;
    logic                   alu_c;

    // sh always holds the next unfolded byte at its LSB, so the ALU never
    // needs a wide byte-select mux.
    byte_alu #(.W(W)) u_alu (
        .op    (op_r),
        .a     (acc),
        .b     (sh[W-1:0]),
        .y     (alu_y),
        .carry (alu_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)         state_nxt = RUN;
            RUN:     if (cnt == LAST_CNT)  state_nxt = DONE;
            DONE:    if (out_ready)        state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '0;
            acc  <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            op_r <= OP_MAX;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sh   <= in_data >> W;
                    acc  <= in_data[W-1:0];
                    cnt  <= 4'd1;
                    ovf  <= 1'b0;
                    op_r <= op_e'(op);
                end
                RUN: begin
                    acc <= alu_y;
                    ovf <= ovf | alu_c;
                    cnt <= cnt + 4'd1;
                    sh  <= sh >> W;
                end
                default: ;
            endcase
        end
    end

    // Result outputs are gated by state so they read zero outside DONE.
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = (state == DONE) ? acc : '0;
    assign out_ovf   = (state == DONE) ? ovf : 1'b0;

endmodule

// File: tb/tb_reduce9_ctrl.sv
module tb_reduce9_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [71:0] in_data = '0;
    logic [1:0]  op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_ovf;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    reduce9_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [71:0] d;
        logic [7:0]  ed;
        logic        eo;
        bit          pre;
        int          hold;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: reduction computed over the byte list with plain integers.
    // Bytes are non-negative, so some 8-bit addition carries iff the true sum exceeds 255.
    function automatic void model(input logic [1:0] o, input logic [71:0] d,
                                  output logic [7:0] r, output logic ovf);
        int m;
        int s;
        int x;
        int b;
        m = (o == 2'd1) ? 255 : 0;
        s = 0;
        x = 0;
        for (int k = 0; k < 9; k++) begin
            b = int'(d[8*k +: 8]);
            if (o == 2'd0 && b > m) m = b;
            if (o == 2'd1 && b < m) m = b;
            s = s + b;
            x = x ^ b;
        end
        ovf = 1'b0;
        case (o)
            2'd0: r = 8'(m);
            2'd1: r = 8'(m);
            2'd2: begin r = 8'(s % 256); ovf = (s > 255); end
            default: r = 8'(x);
        endcase
    endfunction

    function automatic logic [71:0] rand72();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[71:0];
    endfunction

    // Entered and left at a falling edge.
    task automatic run_word(input string nm, input logic [1:0] o, input logic [71:0] d,
                            input logic [7:0] ed, input logic eo, input bit pre, input int hold);
        int lat;
        logic [7:0] d0;
        logic o0;
        bit stable;
        out_ready = pre;
        in_valid  = 1'b1;
        in_data   = d;
        op        = o;
        chk({nm, " in_ready idle"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = rand72();
        op       = 2'($urandom_range(0, 3));
        chk({nm, " busy run"}, 32'(busy), 32'd1);
        chk({nm, " in_ready run"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'd8);
        if (!out_valid) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            out_ready = 1'b0;
            @(negedge clk);
            return;
        end
        chk({nm, " out_data"}, 32'(out_data), 32'(ed));
        chk({nm, " out_ovf"}, 32'(out_ovf), 32'(eo));
        if (!pre) begin
            d0 = out_data;
            o0 = out_ovf;
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                in_valid = (i == hold / 2);
                in_data  = rand72();
                @(negedge clk);
                if (out_valid !== 1'b1 || out_data !== d0 || out_ovf !== o0 || in_ready !== 1'b0)
                    stable = 1'b0;
            end
            in_valid = 1'b0;
            if (hold > 0) chk({nm, " hold stable"}, 32'(stable), 32'd1);
            out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " out_valid after hs"}, 32'(out_valid), 32'd0);
        chk({nm, " in_ready after hs"}, 32'(in_ready), 32'd1);
        chk({nm, " busy after hs"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [71:0] w;
        logic [7:0]  er;
        logic        eo;
        logic [1:0]  ro;

        w = 72'hC9E1D5C1B361D4AAF0;
        tbl[0] = '{2'd0, w, 8'hF0, 1'b0, 1'b0, 0};
        tbl[1] = '{2'd1, w, 8'h61, 1'b0, 1'b0, 20};
        tbl[2] = '{2'd2, w, 8'hC2, 1'b1, 1'b1, 0};
        tbl[3] = '{2'd3, w, 8'h60, 1'b0, 1'b0, 3};
        tbl[4] = '{2'd2, 72'h010101010101010101, 8'h09, 1'b0, 1'b0, 1};
        tbl[5] = '{2'd0, 72'h0, 8'h00, 1'b0, 1'b1, 0};
        tbl[6] = '{2'd1, 72'hFFFFFFFFFFFFFFFFFF, 8'hFF, 1'b0, 1'b0, 2};
        tbl[7] = '{2'd2, 72'h0000000000000001FF, 8'h00, 1'b1, 1'b0, 0};

        // Reset held for three clocks.
        repeat (3) @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", 32'(in_ready), 32'd1);
        chk("post-reset out_valid", 32'(out_valid), 32'd0);
        chk("post-reset out_data", 32'(out_data), 32'd0);
        chk("post-reset out_ovf", 32'(out_ovf), 32'd0);
        chk("post-reset busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++)
            run_word($sformatf("vec%0d", i), tbl[i].op, tbl[i].d, tbl[i].ed, tbl[i].eo,
                     tbl[i].pre, tbl[i].hold);

        // Reset after the fourth fold; the aborted word must leave no trace.
        in_valid = 1'b1;
        in_data  = 72'hC9E1D5C1B361D4AAF0;
        op       = 2'd2;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun rst busy", 32'(busy), 32'd0);
        chk("midrun rst out_valid", 32'(out_valid), 32'd0);
        chk("midrun rst out_data", 32'(out_data), 32'd0);
        chk("midrun rst out_ovf", 32'(out_ovf), 32'd0);
        chk("midrun rst in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_word("after abort", 2'd0, 72'h0000000000000000FF, 8'hFF, 1'b0, 1'b0, 0);

        // Random words against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            w  = rand72();
            if (i % 10 == 3) w = 72'h0;
            if (i % 10 == 7) w = {9{8'hFF}};
            if (i % 10 == 5) w = w & {9{8'h1F}};
            model(ro, w, er, eo);
            run_word($sformatf("rand%0d", i), ro, w, er, eo, bit'($urandom_range(0, 1)),
                     int'($urandom_range(0, 4)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reduce9_ctrl.md
# reduce9_ctrl

Sequencing controller that accepts a 72-bit word of nine packed bytes and folds them one byte per clock through a single shared 8-bit ALU. The ALU applies one of four reductions: max, min, modular sum or XOR. It sits between a 72-bit producer and an 8-bit consumer, with valid/ready handshakes on both sides. It replaces a fully parallel nine-input reduction with one time-multiplexed byte datapath.

## Interface
Parameters:
- `NUM_BYTES`, default 9: bytes per input word.
- `W`, default 8: byte width. Input width is `NUM_BYTES*W`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: producer has a word.
- `in_ready` out 1: controller can accept a word.
- `in_data` in 72: packed bytes. Byte k is `in_data[8k+7:8k]`.
- `op` in 2: reduction select, sampled only on input handshake. 0=MAX, 1=MIN, 2=SUM, 3=XOR.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out 8: reduction result.
- `out_ovf` out 1: SUM only; set if any addition carried out of bit 7.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch `in_data` into the shift register and latch `op`.
  - acc ← byte 0; cnt ← 1; ovf ← 0; go to RUN.
- **RUN**
  - Each edge: acc ← alu(op, acc, byte[cnt]); cnt ← cnt+1.
  - SUM: ovf ← ovf | carry.
  - When cnt = `NUM_BYTES`-1 is folded, go to DONE.
  - `in_ready`=0. `in_valid` is ignored.
- **DONE**
  - `out_valid`=1; `out_data`=acc; `out_ovf`=ovf.
  - All three hold stable until `out_valid && out_ready`. On that edge, go to IDLE.
- ALU (combinational):
  - MAX and MIN are unsigned compares.
  - SUM is 8-bit wrap; carry is bit 8 of the 9-bit sum.
  - XOR is bitwise.
  - `out_ovf` is 0 for MAX, MIN and XOR.
- Byte order is fixed: byte 0 is processed first and byte 8 last.
- No overlap: a new word is accepted only in IDLE, i.e. one cycle after the output handshake at the earliest.
- `op` and `in_data` changes outside the accepting edge have no effect.
- `out_ready` held high in advance is legal. The handshake completes on the first DONE cycle.
- Reset values (all asynchronous on `rst_n`=0):
  - State is IDLE.
  - `in_ready`=1 once reset is released; `out_valid`=0; `out_data`=0; `out_ovf`=0; `busy`=0.
  - acc, cnt and the shift register are 0.
- Reset mid-RUN or mid-DONE discards the word. No output is produced for it.

## Timing
- Accept edge T0 → RUN. Fold edges T1..T8 (8 folds) → DONE is visible after T8.
- `out_valid` rises 8 clocks after the accepting edge.
- Minimum word period is 10 clocks: 1 IDLE + 8 RUN + 1 DONE with `out_ready`=1.
- `in_ready` falls in the cycle after the accepting edge. It rises in the cycle after the output handshake edge.
- `out_valid` deasserts in the cycle after the handshake edge.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Shared package `reduce9_pkg` holds:
  - The op enum: `OP_MAX`=0, `OP_MIN`=1, `OP_SUM`=2, `OP_XOR`=3.
  - The state enum: IDLE, RUN, DONE.
  - `NUM_BYTES`=9 and `W`=8 constants.
- One sub-module, `byte_alu`: purely combinational, with inputs op, a, b and outputs y, carry.
- The top holds the FSM, the 4-bit counter, the 72-bit shift register (shift right by 8 per fold), acc and ovf.

## Test plan
- Reset: hold `rst_n`=0 for 3 clocks → `in_ready`=1 after release; `out_valid`=0, `out_data`=0, `out_ovf`=0, `busy`=0.
- MAX: `in_data`=72'hC9E1D5C1B361D4AAF0, `op`=0 → `out_data`=8'hF0, `out_ovf`=0; `out_valid` rises exactly 8 clocks after acceptance.
- MIN, SUM and XOR on the same word:
  - `op`=1 → 8'h61.
  - `op`=2 → 8'hC2 with `out_ovf`=1 (true sum 0x6C2).
  - `op`=3 → 8'h60.
- Back-pressure: hold `out_ready`=0 for 20 clocks in DONE → `out_data` and `out_valid` stay stable; `in_ready`=0; a new `in_valid` pulse is not accepted.
- No-overflow SUM: `in_data`=72'h010101010101010101, `op`=2 → 8'h09 with `out_ovf`=0.
- Reset mid-RUN: assert `rst_n`=0 at fold 4 → all outputs reset immediately; the next word, 72'h0000000000000000FF with MAX, returns 8'hFF with no residue from the aborted word.
